// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MW-stage load/store engine driving a req/ack data bus
`ifndef DM_OPSLEN
`define DM_OPSLEN 3
`endif
`ifndef DM_OPS_LB
`define DM_OPS_LB  3'd0
`define DM_OPS_LH  3'd1
`define DM_OPS_LW  3'd2
`define DM_OPS_LBU 3'd4
`define DM_OPS_LHU 3'd5
`define DM_OPS_SB  3'd0
`define DM_OPS_SH  3'd1
`define DM_OPS_SW  3'd2
`endif

module load_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [`DM_OPSLEN-1:0] rd_op,
    input  logic [`DM_OPSLEN-1:0] wr_op,
    input  logic [XLEN-1:0]       addr,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata,
    output logic                  lsu_stall,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [XLEN-1:0]       bus_addr,
    output logic [3:0]            bus_be,
    output logic [XLEN-1:0]       bus_wdata,
    input  logic                  bus_ack,
    input  logic [XLEN-1:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  count;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  ofs_q;

    logic        is_store, is_load, req_ok, mis;
    logic [1:0]  size_d;
    logic        sign_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] load_fmt;
    logic        timeout_hit;

    // Decode the request: a valid store op wins over any load, bad op codes mean no request
    always_comb begin
        is_store = 1'b0;
        is_load  = 1'b0;
        size_d   = SZ_WORD;
        sign_d   = 1'b0;
        if (wr_en) begin
            is_store = 1'b1;
            unique case (wr_op)
                `DM_OPS_SB: size_d = SZ_BYTE;
                `DM_OPS_SH: size_d = SZ_HALF;
                `DM_OPS_SW: size_d = SZ_WORD;
                default:    is_store = 1'b0;
            endcase
        end else if (rd_en) begin
            is_load = 1'b1;
            unique case (rd_op)
                `DM_OPS_LB:  begin size_d = SZ_BYTE; sign_d = 1'b1; end
                `DM_OPS_LH:  begin size_d = SZ_HALF; sign_d = 1'b1; end
                `DM_OPS_LW:  size_d = SZ_WORD;
                `DM_OPS_LBU: size_d = SZ_BYTE;
                `DM_OPS_LHU: size_d = SZ_HALF;
                default:     is_load = 1'b0;
            endcase
        end
        req_ok = is_store | is_load;
        mis    = ((size_d == SZ_HALF) && addr[0]) ||
                 ((size_d == SZ_WORD) && (addr[1:0] != 2'b00));
    end

    // Byte enables and lane-replicated store data for the current request
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        unique case (size_d)
            SZ_BYTE: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        lane     = bus_rdata >> {ofs_q, 3'b000};
        load_fmt = bus_rdata;
        unique case (size_q)
            SZ_BYTE: load_fmt = sign_q ? {{24{lane[7]}}, lane[7:0]}   : {24'd0, lane[7:0]};
            SZ_HALF: load_fmt = sign_q ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
            default: load_fmt = bus_rdata;
        endcase
        timeout_hit = (count == LAST_CNT);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: ack beats timeout, DONE always returns to IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_ok) state_nxt = mis ? DONE : REQ;
            REQ:     if (bus_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: stall covers the issuing IDLE cycle and every REQ cycle, dropped at once by reset
    always_comb begin
        bus_req   = (state == REQ);
        lsu_stall = !rst && (((state == IDLE) && req_ok && !mis) || (state == REQ));
    end

    // Bus attributes, timeout counter, load result and one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr   <= '0;
            bus_we     <= 1'b0;
            bus_be     <= 4'd0;
            bus_wdata  <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            count      <= 8'd0;
            size_q     <= SZ_WORD;
            sign_q     <= 1'b0;
            ofs_q      <= 2'd0;
        end else begin
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_ok && mis) begin
                        misaligned <= 1'b1;
                        rdata      <= '0;
                    end else if (req_ok) begin
                        bus_addr  <= {addr[XLEN-1:2], 2'b00};
                        bus_we    <= is_store;
                        bus_be    <= be_d;
                        bus_wdata <= wdata_d;
                        size_q    <= size_d;
                        sign_q    <= sign_d;
                        ofs_q     <= addr[1:0];
                        count     <= 8'd0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!bus_we) rdata <= load_fmt;
                        count <= 8'd0;
                    end else if (timeout_hit) begin
                        rdata   <= '0;
                        bus_err <= 1'b1;
                        count   <= 8'd0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized model-checked bench for load_store_unit
`ifndef DM_OPSLEN
`define DM_OPSLEN 3
`endif
`ifndef DM_OPS_LB
`define DM_OPS_LB  3'd0
`define DM_OPS_LH  3'd1
`define DM_OPS_LW  3'd2
`define DM_OPS_LBU 3'd4
`define DM_OPS_LHU 3'd5
`define DM_OPS_SB  3'd0
`define DM_OPS_SH  3'd1
`define DM_OPS_SW  3'd2
`endif

module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [2:0]  rd_op, wr_op;
    logic [31:0] addr, wdata, bus_rdata;
    logic        bus_ack;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        lsu_stall, misaligned, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;

    load_store_unit #(.TIMEOUT(TIMEOUT), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .rd_op(rd_op), .wr_op(wr_op),
        .addr(addr), .wdata(wdata), .rdata(rdata), .lsu_stall(lsu_stall),
        .misaligned(misaligned), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // per-cycle expectations written by the driver, checked on the falling edge
    logic        chk = 1'b0;
    logic        chk_attr = 1'b0;
    logic        chk_wd = 1'b0;
    logic        e_stall, e_req, e_mis, e_err, e_we;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [31:0] model_rdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int op_bytes(input bit st, input logic [2:0] op);
        if (st) begin
            case (op)
                `DM_OPS_SB: return 1;
                `DM_OPS_SH: return 2;
                `DM_OPS_SW: return 4;
                default:    return 0;
            endcase
        end
        case (op)
            `DM_OPS_LB, `DM_OPS_LBU: return 1;
            `DM_OPS_LH, `DM_OPS_LHU: return 2;
            `DM_OPS_LW:              return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [31:0] d, input int b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % b) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] w, input int o, input int b, input bit sgn);
        logic [31:0] v, mask;
        mask = (b == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*b)) - 32'd1);
        v = (w >> (8*o)) & mask;
        if (sgn && b < 4 && v[8*b-1]) v = v | ~mask;
        return v;
    endfunction

    // compare process: every checked cycle, all visible outputs against the model
    always @(negedge clk) begin
        if (chk) begin
            check("lsu_stall", {31'd0, lsu_stall}, {31'd0, e_stall});
            check("bus_req", {31'd0, bus_req}, {31'd0, e_req});
            check("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
            check("bus_err", {31'd0, bus_err}, {31'd0, e_err});
            check("rdata", rdata, e_rdata);
            if (chk_attr) begin
                check("bus_we", {31'd0, bus_we}, {31'd0, e_we});
                check("bus_be", {28'd0, bus_be}, {28'd0, e_be});
                check("bus_addr", bus_addr, e_addr);
                if (chk_wd) check("bus_wdata", bus_wdata, e_wdata);
            end
        end
    end

    // one instruction in MW: held from its IDLE cycle through DONE; ack_at = 0 means never ack
    task automatic do_txn(input logic rd, input logic wr, input logic [2:0] rop, input logic [2:0] wop,
                          input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                          input logic [31:0] rw, input bit lit, input logic [31:0] l_rdata,
                          input logic [3:0] l_be, input logic [31:0] l_addr, input logic [31:0] l_wdata);
        int  bytes, n, o;
        bit  st, sgn, mis;
        st    = wr;
        bytes = (wr || rd) ? op_bytes(st, wr ? wop : rop) : 0;
        sgn   = !st && (rop == `DM_OPS_LB || rop == `DM_OPS_LH);
        o     = int'(a[1:0]);

        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; rd_op = rop; wr_op = wop; addr = a; wdata = wd;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        chk_attr = 0; e_req = 0; e_mis = 0; e_err = 0; e_rdata = model_rdata;
        chk = 1;
        if (bytes == 0) begin
            e_stall = 0;
            return;
        end
        mis = (o % bytes) != 0;
        e_stall = !mis;
        if (mis) begin
            @(posedge clk); #1;
            bus_ack = 1'($urandom);
            model_rdata = 32'd0;
            e_stall = 0; e_mis = 1; e_rdata = model_rdata;
            if (lit) begin
                @(negedge clk);
                check("lit_mis_rdata", rdata, l_rdata);
                check("lit_mis_pulse", {31'd0, misaligned}, 32'd1);
            end
            return;
        end
        n = (ack_at == 0) ? TIMEOUT : ack_at;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            e_req = 1; e_stall = 1; chk_attr = 1; chk_wd = st;
            e_we = st; e_addr = a & 32'hFFFF_FFFC;
            e_be = 4'(((1 << bytes) - 1) << o);
            e_wdata = replicate(wd, bytes);
            bus_ack = (k == ack_at);
            bus_rdata = (k == ack_at) ? rw : $urandom;
            if (lit && k == 1) begin
                @(negedge clk);
                check("lit_be", {28'd0, bus_be}, {28'd0, l_be});
                check("lit_addr", bus_addr, l_addr);
                if (st) begin
                    check("lit_wdata", bus_wdata, l_wdata);
                    check("lit_we", {31'd0, bus_we}, 32'd1);
                end
            end
        end
        @(posedge clk); #1;
        chk_attr = 0; e_req = 0; e_stall = 0;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        if (ack_at == 0) begin
            model_rdata = 32'd0;
            e_err = 1;
        end else if (!st) begin
            model_rdata = load_value(rw, o, bytes, sgn);
        end
        e_rdata = model_rdata;
        if (lit) begin
            @(negedge clk);
            check("lit_rdata", rdata, l_rdata);
            check("lit_err", {31'd0, bus_err}, (ack_at == 0) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; rd_en = 0; wr_en = 0; rd_op = 0; wr_op = 0; addr = 0; wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        #12;
        check("rst_rdata", rdata, 32'd0);
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_stall", {31'd0, lsu_stall}, 32'd0);
        check("rst_be", {28'd0, bus_be}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_pulses", {30'd0, misaligned, bus_err}, 32'd0);
        @(posedge clk); #1; rst = 0;

        // hand-computed scenarios
        do_txn(1, 0, `DM_OPS_LW, 0, 32'h100, 0, 2, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'hF, 32'h100, 0);
        do_txn(1, 0, `DM_OPS_LB, 0, 32'h103, 0, 1, 32'h80FF7F01, 1, 32'hFFFFFF80, 4'h8, 32'h100, 0);
        do_txn(1, 0, `DM_OPS_LBU, 0, 32'h103, 0, 1, 32'h80FF7F01, 1, 32'h00000080, 4'h8, 32'h100, 0);
        do_txn(0, 1, 0, `DM_OPS_SH, 32'h202, 32'h0000ABCD, 1, 0, 1, 32'h00000080, 4'hC, 32'h200, 32'hABCDABCD);
        do_txn(1, 0, `DM_OPS_LW, 0, 32'h101, 0, 1, 0, 1, 32'd0, 4'h0, 0, 0);
        do_txn(1, 0, `DM_OPS_LHU, 0, 32'h102, 0, 1, 32'hBEEF1234, 1, 32'h0000BEEF, 4'hC, 32'h100, 0);
        do_txn(0, 1, 0, `DM_OPS_SH, 32'h0FF, 32'h1234, 1, 0, 1, 32'd0, 4'h0, 0, 0);
        do_txn(1, 0, `DM_OPS_LW, 0, 32'h300, 0, 0, 0, 1, 32'd0, 4'hF, 32'h300, 0);
        do_txn(1, 0, `DM_OPS_LW, 0, 32'h304, 0, TIMEOUT, 32'hCAFEF00D, 1, 32'hCAFEF00D, 4'hF, 32'h304, 0);
        do_txn(1, 1, `DM_OPS_LW, `DM_OPS_SB, 32'h401, 32'h77, 1, 32'h55555555, 1, 32'hCAFEF00D, 4'h2, 32'h400, 32'h77777777);

        // reset on the 2nd REQ cycle of a load, then the held request reissues
        @(posedge clk); #1;
        chk = 0;
        rd_en = 1; wr_en = 0; rd_op = `DM_OPS_LW; addr = 32'h40; bus_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_req_before", {31'd0, bus_req}, 32'd1);
        rst = 1; #1;
        check("rst_mid_req", {31'd0, bus_req}, 32'd0);
        check("rst_mid_stall", {31'd0, lsu_stall}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        model_rdata = 32'd0;
        @(posedge clk); #1; rst = 0; #1;
        check("rst_re_stall", {31'd0, lsu_stall}, 32'd1);
        @(posedge clk); #1;
        check("rst_re_req", {31'd0, bus_req}, 32'd1);
        check("rst_re_addr", bus_addr, 32'h40);
        bus_ack = 1; bus_rdata = 32'h12345678;
        @(posedge clk); #1;
        bus_ack = 0;
        check("rst_re_rdata", rdata, 32'h12345678);
        check("rst_re_done_stall", {31'd0, lsu_stall}, 32'd0);
        model_rdata = 32'h12345678;

        // randomized traffic
        for (int t = 0; t < 200; t++) begin
            logic        r, w;
            logic [2:0]  ro, wo;
            logic [31:0] a;
            int          ack, kind;
            kind = int'($urandom_range(0, 9));
            r = (kind != 0) && ($urandom_range(0, 2) != 0);
            w = (kind != 0) && !r ? 1'b1 : 1'($urandom_range(0, 4) == 0);
            ro = 3'($urandom);
            wo = 3'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            ack = int'($urandom_range(0, 15));
            if (ack == 0) ack = 0;
            else if (ack == 15) ack = TIMEOUT;
            else ack = (ack % 4) + 1;
            do_txn(r, w, ro, wo, a, $urandom, ack, $urandom, 0, 0, 0, 0, 0);
        end

        @(posedge clk); #1;
        rd_en = 0; wr_en = 0; e_stall = 0; e_req = 0; e_mis = 0; e_err = 0; e_rdata = model_rdata;
        @(posedge clk); #1;
        chk = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
